l2_arbiter: RTL and testbench

- Shares the single unified L2 cache port between the split L1 I-cache (fetch) and the L1 D-cache (MEM stage).
- Accepts line-granularity miss/writeback requests from both L1s and serializes them onto the L2 port one at a time.
- Round-robin arbitration on conflicts; the D-cache wins the first tie after reset.
- Latches the request at grant and returns the L2 line to the granted requester with a one-cycle response pulse.

---
 rtl/l2_arbiter.sv | 163 ++++++++++++++++
 tb/tb_l2_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// -----------------------------------------------------------------------------
// l2_arbiter
// Shares the single unified L2 port between the L1 I-cache and L1 D-cache.
// Requests from both L1s are serialized one at a time, with round-robin on
// conflicts (D wins the first tie after reset). The request is latched at
// grant, and the returned line goes to the granted requester with a one-cycle
// resp pulse.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_read, i_address       I-cache line read request (held until i_resp)
//   i_rdata, i_resp         line returned to I-cache, completion pulse
//   d_read, d_write         D-cache fill / writeback request (held until d_resp)
//   d_address, d_wdata      D-cache line address and writeback line
//   d_rdata, d_resp         line returned to D-cache, completion pulse
//   l2_read, l2_write       registered L2 command (never both high)
//   l2_address, l2_wdata    latched address / writeback data
//   l2_rdata, l2_resp       L2 read data and single-cycle completion
// -----------------------------------------------------------------------------
module l2_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic [LINE_WIDTH-1:0] l2_rdata,
   input  logic                  l2_resp
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SERVE_I,
      ST_SERVE_D,
      ST_DONE_I,
      ST_DONE_D
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_last_d;      // 1: last grant went to D, 0: to I
   logic                  r_l2_read;
   logic                  r_l2_write;
   logic [ADDR_WIDTH-1:0] r_l2_address;
   logic [LINE_WIDTH-1:0] r_l2_wdata;
   logic [LINE_WIDTH-1:0] r_i_rdata;
   logic [LINE_WIDTH-1:0] r_d_rdata;

   logic                  w_d_req;
   logic                  w_grant_i;
   logic                  w_grant_d;
   logic                  w_serving;

   assign w_d_req   = d_read | d_write;
   assign w_serving = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D);

   // ---------------------------------------------------------------------------
   // Next-state and grant decision
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case leaves a signal unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_read && w_d_req) begin
               // Tie: grant whoever did not win last time.
               w_grant_i = r_last_d;
               w_grant_d = ~r_last_d;
            end else begin
               w_grant_i = i_read;
               w_grant_d = w_d_req;
            end
            if (w_grant_i) w_state_nxt = ST_SERVE_I;
            if (w_grant_d) w_state_nxt = ST_SERVE_D;
         end
         ST_SERVE_I: if (l2_resp) w_state_nxt = ST_DONE_I;
         ST_SERVE_D: if (l2_resp) w_state_nxt = ST_DONE_D;
         // A request still high in DONE is picked up from IDLE, never here.
         ST_DONE_I:  w_state_nxt = ST_IDLE;
         ST_DONE_D:  w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Request latch, L2 command and response data
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the wide line registers are reset too, because the returned data
      // and the L2 address/data buses must read as zero out of reset.
      if (!rst_n) begin
         r_last_d     <= 1'b0;
         r_l2_read    <= 1'b0;
         r_l2_write   <= 1'b0;
         r_l2_address <= '0;
         r_l2_wdata   <= '0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
      end else begin
         if (w_grant_i) begin
            r_l2_address <= i_address;
            r_l2_read    <= 1'b1;
            r_last_d     <= 1'b0;
         end
         if (w_grant_d) begin
            r_l2_address <= d_address;
            r_last_d     <= 1'b1;
            // A simultaneous read+write is a protocol error; the write wins.
            if (d_write) begin
               r_l2_write <= 1'b1;
               r_l2_wdata <= d_wdata;
            end else begin
               r_l2_read  <= 1'b1;
            end
         end
         if (w_serving && l2_resp) begin
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            // Only reads return a line; a writeback leaves rdata untouched.
            if (r_l2_read) begin
               if (r_state == ST_SERVE_I) r_i_rdata <= l2_rdata;
               else                       r_d_rdata <= l2_rdata;
            end
         end
      end
   end

   assign l2_read    = r_l2_read;
   assign l2_write   = r_l2_write;
   assign l2_address = r_l2_address;
   assign l2_wdata   = r_l2_wdata;
   assign i_rdata    = r_i_rdata;
   assign d_rdata    = r_d_rdata;
   assign i_resp     = (r_state == ST_DONE_I);
   assign d_resp     = (r_state == ST_DONE_D);

endmodule

// File: tb/tb_l2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_arbiter
// Directed bench for l2_arbiter: a table of lone transactions followed by
// hand-written sequences for ties, fairness, reset mid-transaction, spurious
// L2 responses and the read+write protocol error. A small L2 responder answers
// each command after a programmable number of cycles.
// -----------------------------------------------------------------------------
module tb_l2_arbiter;

   localparam logic [127:0] GARBAGE = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_read;
   logic [15:0]  i_address;
   logic [127:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [15:0]  d_address;
   logic [127:0] d_wdata;
   logic [127:0] d_rdata;
   logic         d_resp;
   logic         l2_read;
   logic         l2_write;
   logic [15:0]  l2_address;
   logic [127:0] l2_wdata;
   logic [127:0] l2_rdata;
   logic         l2_resp;

   always #5 clk = ~clk;

   l2_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_read     (i_read),
      .i_address  (i_address),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_address  (d_address),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .l2_read    (l2_read),
      .l2_write   (l2_write),
      .l2_address (l2_address),
      .l2_wdata   (l2_wdata),
      .l2_rdata   (l2_rdata),
      .l2_resp    (l2_resp)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // L2 responder: in auto mode answers after l2_lat command cycles; in manual
   // mode simply forwards man_resp.
   // ---------------------------------------------------------------------------
   logic         l2_auto = 1'b1;
   logic         man_resp = 1'b0;
   int           l2_lat = 1;
   logic [127:0] l2_data = '0;
   int           lat_cnt = 0;

   initial begin
      l2_resp  = 1'b0;
      l2_rdata = GARBAGE;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         lat_cnt  = 0;
         l2_resp  = 1'b0;
         l2_rdata = GARBAGE;
      end else if (l2_auto) begin
         if (l2_resp) begin
            l2_resp  = 1'b0;
            l2_rdata = GARBAGE;
            lat_cnt  = 0;
         end else if (l2_read || l2_write) begin
            lat_cnt++;
            if (lat_cnt >= l2_lat) begin
               l2_resp  = 1'b1;
               l2_rdata = l2_data;
            end
         end
      end else begin
         l2_resp  = man_resp;
         l2_rdata = man_resp ? l2_data : GARBAGE;
      end
   end

   // ---------------------------------------------------------------------------
   // Observer: logs each new L2 command, counts responses, checks invariants.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [15:0]  addr;
      logic         wr;
      logic [127:0] wdata;
      int           cyc;
   } cmd_t;

   cmd_t         log_q[$];
   int           cyc = 0;
   int           n_iresp = 0;
   int           n_dresp = 0;
   int           n_viol = 0;
   int           n_l2rd = 0;
   int           last_dresp_cyc = 0;
   logic         prev_cmd = 1'b0;
   logic [15:0]  prev_addr = '0;
   logic [127:0] prev_wdata = '0;

   always @(negedge clk) begin
      cyc++;
      if (i_resp) n_iresp++;
      if (d_resp) begin
         n_dresp++;
         last_dresp_cyc = cyc;
      end
      if (l2_read) n_l2rd++;
      if (l2_read && l2_write) n_viol++;
      if (i_resp && d_resp) n_viol++;
      if ((l2_read || l2_write) && prev_cmd &&
          ((l2_address !== prev_addr) || (l2_wdata !== prev_wdata))) n_viol++;
      if ((l2_read || l2_write) && !prev_cmd)
         log_q.push_back('{l2_address, l2_write, l2_wdata, cyc});
      prev_cmd   = l2_read || l2_write;
      prev_addr  = l2_address;
      prev_wdata = l2_wdata;
   end

   // ---------------------------------------------------------------------------
   // Lone-transaction vectors. exp_wait is the number of falling edges from the
   // drive edge to the edge where resp is seen: with the request cycle counted
   // as 1, resp lands in cycle L+2, i.e. L+1 edges later.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic         is_d;
      logic         is_wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
      logic [127:0] l2data;
      int           lat;
      int           exp_wait;
      logic [127:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_vec(input int k);
      vec_t v;
      int   base, i0, d0, waited;
      logic got;
      v    = vecs[k];
      base = log_q.size();
      i0   = n_iresp;
      d0   = n_dresp;
      l2_lat  = v.lat;
      l2_data = v.l2data;
      @(negedge clk);
      if (v.is_d) begin
         d_address = v.addr;
         d_wdata   = v.wdata;
         d_write   = v.is_wr;
         d_read    = ~v.is_wr;
      end else begin
         i_address = v.addr;
         i_read    = 1'b1;
      end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 20) begin
         @(negedge clk);
         waited++;
         got = v.is_d ? d_resp : i_resp;
      end
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("v%0d latency", k), waited, v.exp_wait);
      check($sformatf("v%0d rdata", k), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
      check($sformatf("v%0d own resp count", k), v.is_d ? n_dresp - d0 : n_iresp - i0, 1);
      check($sformatf("v%0d other resp count", k), v.is_d ? n_iresp - i0 : n_dresp - d0, 0);
      check($sformatf("v%0d l2 cmd count", k), log_q.size() - base, 1);
      if (log_q.size() > base) begin
         check($sformatf("v%0d l2 addr", k), log_q[base].addr, v.addr);
         check($sformatf("v%0d l2 op", k), log_q[base].wr, v.is_wr);
         if (v.is_wr) check($sformatf("v%0d l2 wdata", k), log_q[base].wdata, v.wdata);
      end
   endtask

   initial begin
      int   base, i0, d0, rd0, ic, dc, n;
      logic i_done, d_done;

      vecs[0] = '{1'b0, 1'b0, 16'h1230, '0,
                  128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AA01, 3, 4,
                  128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AA01};
      vecs[1] = '{1'b1, 1'b1, 16'h8040, {16{8'h55}},
                  128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 2, 3, 128'h0};
      vecs[2] = '{1'b1, 1'b0, 16'h2000, '0,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 2,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
      vecs[3] = '{1'b0, 1'b0, 16'h0FF0, '0,
                  128'hC0DE_C0DE_1111_2222_3333_4444_5555_6666, 5, 6,
                  128'hC0DE_C0DE_1111_2222_3333_4444_5555_6666};
      vecs[4] = '{1'b1, 1'b1, 16'h4440, {32{4'h1}},
                  128'h9999_9999_9999_9999_9999_9999_9999_9999, 1, 2,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};

      rst_n     = 1'b0;
      i_read    = 1'b0;
      i_address = '0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      d_address = '0;
      d_wdata   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset l2_read", l2_read, 0);
      check("reset l2_write", l2_write, 0);
      check("reset l2_address", l2_address, 0);
      check("reset l2_wdata", l2_wdata, 0);
      check("reset i_rdata", i_rdata, 0);
      check("reset d_rdata", d_rdata, 0);
      check("reset i_resp", i_resp, 0);
      check("reset d_resp", d_resp, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 5; k++) run_vec(k);

      // Simultaneous requests right after reset: D first, I after one IDLE.
      do_reset();
      base    = log_q.size();
      l2_lat  = 2;
      l2_data = 128'h5A5A_0000_0000_0000_0000_0000_0000_A5A5;
      i_address = 16'h1111;
      d_address = 16'h2222;
      i_read    = 1'b1;
      d_read    = 1'b1;
      i_done    = 1'b0;
      d_done    = 1'b0;
      n = 0;
      while (!(i_done && d_done) && n < 40) begin
         @(negedge clk);
         n++;
         if (i_resp) begin i_read = 1'b0; i_done = 1'b1; end
         if (d_resp) begin d_read = 1'b0; d_done = 1'b1; end
      end
      repeat (3) @(negedge clk);
      check("tie both completed", {i_done, d_done}, 2'b11);
      check("tie cmd count", log_q.size() - base, 2);
      if (log_q.size() >= base + 2) begin
         check("tie first addr", log_q[base].addr, 16'h2222);
         check("tie second addr", log_q[base+1].addr, 16'h1111);
         check("tie spacing d_resp to next cmd", log_q[base+1].cyc - last_dresp_cyc, 2);
      end

      // Fairness: D write, then immediate D fill, with I held high.
      base = log_q.size();
      l2_lat    = 1;
      i_address = 16'h3330;
      d_address = 16'h4440;
      d_wdata   = 128'hFACE_FACE_FACE_FACE_FACE_FACE_FACE_FACE;
      i_read    = 1'b1;
      d_write   = 1'b1;
      ic = 0;
      dc = 0;
      n  = 0;
      while (!(ic == 1 && dc == 2) && n < 60) begin
         @(negedge clk);
         n++;
         if (i_resp) begin i_read = 1'b0; ic++; end
         if (d_resp) begin
            if (dc == 0) begin
               d_write   = 1'b0;
               d_read    = 1'b1;
               d_address = 16'h5550;
            end else begin
               d_read = 1'b0;
            end
            dc++;
         end
      end
      repeat (3) @(negedge clk);
      check("fair resp counts", {ic[3:0], dc[3:0]}, 8'h12);
      check("fair cmd count", log_q.size() - base, 3);
      if (log_q.size() >= base + 3) begin
         check("fair 1st addr", log_q[base].addr, 16'h4440);
         check("fair 1st op", log_q[base].wr, 1'b1);
         check("fair 2nd addr", log_q[base+1].addr, 16'h3330);
         check("fair 2nd op", log_q[base+1].wr, 1'b0);
         check("fair 3rd addr", log_q[base+2].addr, 16'h5550);
         check("fair 3rd op", log_q[base+2].wr, 1'b0);
      end

      // Reset mid-transaction, then a spurious l2_resp in IDLE.
      do_reset();
      l2_auto   = 1'b0;
      l2_data   = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
      d_address = 16'h6660;
      d_read    = 1'b1;
      repeat (2) @(negedge clk);
      check("mid-op l2_read before reset", l2_read, 1'b1);
      check("mid-op l2_address before reset", l2_address, 16'h6660);
      #2 rst_n = 1'b0;
      #1;
      check("async reset l2_read", l2_read, 1'b0);
      check("async reset l2_address", l2_address, 16'h0);
      check("async reset d_resp", d_resp, 1'b0);
      d_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      d0 = n_dresp;
      i0 = n_iresp;
      repeat (2) @(negedge clk);
      man_resp = 1'b1;
      @(negedge clk);
      man_resp = 1'b0;
      repeat (4) @(negedge clk);
      check("spurious l2_resp d_resp count", n_dresp - d0, 0);
      check("spurious l2_resp i_resp count", n_iresp - i0, 0);
      check("spurious l2_resp l2 cmd", {l2_read, l2_write}, 2'b00);
      check("spurious l2_resp d_rdata", d_rdata, 0);

      // d_read and d_write together: only the write is issued.
      l2_auto = 1'b1;
      l2_lat  = 2;
      base = log_q.size();
      d0   = n_dresp;
      rd0  = n_l2rd;
      d_address = 16'h7770;
      d_wdata   = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
      d_read    = 1'b1;
      d_write   = 1'b1;
      n = 0;
      d_done = 1'b0;
      while (!d_done && n < 20) begin
         @(negedge clk);
         n++;
         d_done = d_resp;
      end
      d_read  = 1'b0;
      d_write = 1'b0;
      repeat (3) @(negedge clk);
      check("rw-both d_resp count", n_dresp - d0, 1);
      check("rw-both l2_read cycles", n_l2rd - rd0, 0);
      check("rw-both cmd count", log_q.size() - base, 1);
      if (log_q.size() > base) begin
         check("rw-both op", log_q[base].wr, 1'b1);
         check("rw-both wdata", log_q[base].wdata, 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD);
      end
      check("rw-both d_rdata unchanged", d_rdata, 0);

      check("invariant violations", n_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
